// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared state encoding, bit-order constants and counter sizing for piso/sipo
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Legacy-style state constants, tied to the enum encoding.
  localparam logic [0:0] ST_IDLE  = 1'(IDLE);
  localparam logic [0:0] ST_SHIFT = 1'(SHIFT);

  // Bit-order selectors shared with the sipo side.
  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

  // Bit counter width: $clog2(WIDTH), never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out stage feeding the sipo deserializer
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             tx_ready,
  output logic             serial_out,
  output logic             shift_en,
  output logic             busy,
  output logic             frame_done
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [CNT_W-1:0] cnt;
  logic             frame_done_r;
  logic             last_bit;
  logic             accept;

  // A bit is taken only while a word is in flight and downstream is not stalling.
  assign shift_en   = (state == ST_SHIFT) && tx_ready;
  assign last_bit   = shift_en && (cnt == CNT_LAST);
  // Ready on the last-bit cycle too, so consecutive words stream with no gap.
  assign load_ready = (state == ST_IDLE) || last_bit;
  assign accept     = load_valid && load_ready;
  assign serial_out = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign busy       = (state == ST_SHIFT);
  assign frame_done = frame_done_r;

  // Shift register moved one place toward the transmit end with zero fill.
  always_comb begin
    shreg_next = '0;
    if (MSB_FIRST) begin
      shreg_next = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      shreg_next = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  // Word capture, per-bit shifting, stall hold and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      cnt          <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= last_bit;
      if (accept) begin
        shreg <= load_data;
        cnt   <= '0;
        state <= ST_SHIFT;
      end else if (shift_en) begin
        shreg <= shreg_next;
        if (cnt == CNT_LAST) begin
          cnt   <= '0;
          state <= ST_IDLE;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer in both bit orders
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk        = 1'b0;
  logic         rst        = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data  = '0;
  logic         tx_ready   = 1'b1;

  logic m_ready, m_ser, m_sh, m_busy, m_done;
  logic l_ready, l_ser, l_sh, l_busy, l_done;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(m_ready), .tx_ready(tx_ready), .serial_out(m_ser),
    .shift_en(m_sh), .busy(m_busy), .frame_done(m_done)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(l_ready), .tx_ready(tx_ready), .serial_out(l_ser),
    .shift_en(l_sh), .busy(l_busy), .frame_done(l_done)
  );

  always #5 clk = ~clk;

  // Reference model: bits still owed for the word in flight, plus expected words.
  int           remaining  = 0;
  logic         frame_exp  = 1'b0;
  int           frames_exp = 0;
  logic [W-1:0] exp_m[$];
  logic [W-1:0] exp_l[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= 0;
      frame_exp <= 1'b0;
    end else begin
      frame_exp <= (remaining == 1) && tx_ready;
      if ((remaining == 1) && tx_ready) frames_exp <= frames_exp + 1;
      if (load_valid && ((remaining == 0) || ((remaining == 1) && tx_ready))) begin
        exp_m.push_back(load_data);
        exp_l.push_back(load_data);
        remaining <= W;
      end else if ((remaining > 0) && tx_ready) begin
        remaining <= remaining - 1;
      end
    end
  end

  int   n_checks  = 0;
  int   n_fail    = 0;
  bit   bound_hit = 1'b0;
  bit   end_phase = 1'b0;
  bit   tx_rand   = 1'b0;
  event probe_ev;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle output checks at negedge; probe events check async reset and final totals.
  initial begin
    int           m_cnt = 0, l_cnt = 0, m_frames = 0, l_frames = 0, k;
    logic [W-1:0] m_word = '0, l_word = '0, wm, wl;
    int           exp_ready, exp_sh, exp_busy;
    forever begin
      @(negedge clk or probe_ev);
      if (clk) begin
        if (end_phase) begin
          chk("frames_m", m_frames, frames_exp);
          chk("frames_l", l_frames, frames_exp);
          chk("queue_drained_m", exp_m.size(), 0);
          chk("queue_drained_l", exp_l.size(), 0);
          chk("wait_bound", int'(bound_hit), 0);
        end else begin
          chk("async_ser_m", m_ser, 0);
          chk("async_shift_en_m", m_sh, 0);
          chk("async_busy_m", m_busy, 0);
          chk("async_load_ready_m", m_ready, 1);
          chk("async_ser_l", l_ser, 0);
          chk("async_busy_l", l_busy, 0);
        end
      end else begin
        exp_ready = ((remaining == 0) || ((remaining == 1) && tx_ready)) ? 1 : 0;
        exp_sh    = ((remaining > 0) && tx_ready) ? 1 : 0;
        exp_busy  = (remaining > 0) ? 1 : 0;
        chk("load_ready_m", m_ready, exp_ready);
        chk("load_ready_l", l_ready, exp_ready);
        chk("shift_en_m", m_sh, exp_sh);
        chk("shift_en_l", l_sh, exp_sh);
        chk("busy_m", m_busy, exp_busy);
        chk("busy_l", l_busy, exp_busy);
        chk("frame_done_m", m_done, int'(frame_exp));
        chk("frame_done_l", l_done, int'(frame_exp));
        if (!rst) begin
          exp_m.delete();
          exp_l.delete();
          m_cnt = 0;
          l_cnt = 0;
          chk("reset_ser_m", m_ser, 0);
          chk("reset_ser_l", l_ser, 0);
        end else begin
          if (m_done) m_frames++;
          if (l_done) l_frames++;
          if (remaining > 0) begin
            k = W - remaining;
            if (exp_m.size() == 0 || exp_l.size() == 0) begin
              chk("queue_underrun", 1, 0);
            end else begin
              wm = exp_m[0];
              wl = exp_l[0];
              chk("ser_m", m_ser, wm[W-1-k]);
              chk("ser_l", l_ser, wl[k]);
            end
          end else begin
            chk("ser_idle_m", m_ser, 0);
            chk("ser_idle_l", l_ser, 0);
          end
          if (m_sh) begin
            m_word[W-1-m_cnt] = m_ser;
            m_cnt++;
            if (m_cnt == W) begin
              m_cnt = 0;
              if (exp_m.size() == 0) chk("word_underrun_m", 1, 0);
              else chk("word_m", m_word, exp_m.pop_front());
            end
          end
          if (l_sh) begin
            l_word[l_cnt] = l_ser;
            l_cnt++;
            if (l_cnt == W) begin
              l_cnt = 0;
              if (exp_l.size() == 0) chk("word_underrun_l", 1, 0);
              else chk("word_l", l_word, exp_l.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (tx_rand) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Holds load_valid until the model says the word is taken at the coming edge.
  task automatic send(input logic [W-1:0] d);
    bit acc;
    int guard;
    guard      = 0;
    load_valid = 1'b1;
    load_data  = d;
    do begin
      acc = (remaining == 0) || ((remaining == 1) && tx_ready);
      step();
      guard++;
    end while (!acc && guard < 200);
    if (!acc) bound_hit = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    send(8'hAA); load_valid = 1'b0; idle(12);

    send(8'hAA); send(8'hCC); load_valid = 1'b0; idle(12);

    send(8'hF0); load_valid = 1'b0; idle(3);
    tx_ready = 1'b0; idle(3);
    tx_ready = 1'b1; idle(12);

    send(8'h01); load_valid = 1'b0; idle(2);
    load_valid = 1'b1; load_data = 8'hFF; step();
    load_valid = 1'b0; idle(8);
    send(8'h3C); load_valid = 1'b0; idle(12);

    send(8'hA5); load_valid = 1'b0; idle(4);
    #2 rst = 1'b0;
    #1 -> probe_ev;
    idle(2);
    rst = 1'b1;
    send(8'h55); load_valid = 1'b0; idle(12);

    tx_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      load_valid = 1'($urandom_range(0, 1));
      load_data  = W'($urandom);
      step();
    end
    load_valid = 1'b0;
    tx_rand    = 1'b0;
    tx_ready   = 1'b1;
    idle(20);

    end_phase = 1'b1;
    -> probe_ev;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out stage that sits directly upstream of the sipo block. It accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on serial_out, qualified by shift_en. serial_out and shift_en wire straight to the deserializer's serial_in and shift_en inputs. Back-to-back words stream with no idle bubble, and a downstream hold input stalls the stream.

Parameters:
WIDTH, 8, word length in bits (>= 2); must match the downstream sipo WIDTH
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
load_valid  input  1  load_data is valid this cycle
load_data  input  WIDTH  parallel word to serialize
load_ready  output  1  block can accept a word this cycle (combinational)
tx_ready  input  1  downstream may take a bit this cycle; 0 = stall (tie to 1 when unused)
serial_out  output  1  current bit of the word in flight
shift_en  output  1  serial_out is valid and advances at this edge
busy  output  1  a word is in flight (state == SHIFT)
frame_done  output  1  one-cycle pulse after the last bit of a word is taken

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, shift register = 0, bit counter = 0, frame_done = 0.
  - Outputs during and after reset: serial_out = 0, shift_en = 0, busy = 0, load_ready = 1.
- States:
  - IDLE: no word held.
  - SHIFT: word in flight; counter cnt holds 0..WIDTH-1 and is $clog2(WIDTH) bits wide.
- Accept: load_valid && load_ready at a rising edge.
  - Shift register <= load_data, cnt <= 0, state <= SHIFT.
  - load_data is sampled only at the accepting edge.
- load_ready = (state == IDLE) || (state == SHIFT && cnt == WIDTH-1 && tx_ready).
  - load_valid while load_ready = 0 is ignored; the word is not captured.
- serial_out = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]; it is driven from the register, not from load_data.
- shift_en = (state == SHIFT) && tx_ready.
- SHIFT step (tx_ready = 1):
  - Shift register shifts toward the transmit end (left if MSB_FIRST, right otherwise) and fills with 0.
  - cnt increments.
- Stall (tx_ready = 0): shift register, cnt and state hold; serial_out is stable; shift_en = 0.
- Last bit (cnt == WIDTH-1 && tx_ready):
  - Next edge: frame_done = 1 for exactly one cycle (registered).
  - If load_valid is also high at that edge, the new word loads and state stays SHIFT, giving zero gap between words.
  - Otherwise state goes to IDLE.
- Latency: a word accepted at edge N drives shift_en high in cycles N+1 .. N+WIDTH when there are no stalls. Each stall cycle adds one cycle.
- Each word produces exactly WIDTH shift_en-qualified bits. frame_done count equals the number of words accepted and completed.
- tx_ready is ignored in IDLE.
- Reset mid-frame aborts immediately: the partial word is discarded and frame_done does not assert.

Decomposition:
- Shared package:
  - state enum {IDLE, SHIFT}.
  - Counter-width localparam CNT_W = $clog2(WIDTH).
  - The bit-order constants MSB_FIRST / LSB_FIRST, so the sipo side can reuse them.
- Single module; no sub-module is warranted. The counter and shift register are a few lines each.

Test Plan:
- Reset then load 8'hAA (MSB_FIRST = 1), tx_ready = 1 -> serial_out 1,0,1,0,1,0,1,0 in the 8 cycles shift_en = 1; frame_done high for one cycle after the 8th; busy = 0 and load_ready = 1 afterward.
- Back-to-back: 8'hAA, then 8'hCC presented while the last bit is sent -> 16 consecutive shift_en cycles with bits 10101010 11001100; load_ready = 1 only in IDLE and on the last-bit cycle; two frame_done pulses, 8 cycles apart.
- Stall: load 8'hF0, hold tx_ready = 0 for 3 cycles at cnt = 3 -> serial_out holds 1 and shift_en = 0 for those 3 cycles; the stream resumes 0,0,0,0; frame_done is delayed by 3 cycles.
- MSB_FIRST = 0, load 8'h01 -> bits 1,0,0,0,0,0,0,0; load_valid with 8'hFF at cnt = 2 -> ignored (load_ready = 0), next word is not 8'hFF.
- Reset mid-frame: assert rst = 0 at cnt = 4 -> serial_out = 0, shift_en = 0, busy = 0 immediately (asynchronous); no frame_done; the next load 8'h55 serializes cleanly.
- Loopback into sipo (WIDTH = 8): feed 8'hAA then 8'hCC -> data_valid pulses twice; parallel_out equals each word in that block's bit order.
